// File: rtl/synapse_pkg.sv
// Shared definitions for the synapse accumulator: FSM encodings, default
// widths and the width-generic saturating adder.
package synapse_pkg;

  localparam int DEF_NUM_CONN = 8;
  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_WEIGHT_W = 16;
  localparam int DEF_ACC_W    = 24;

  // Widest accumulator the saturating helper supports.
  localparam int SAT_MAX_W    = 64;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCUM  = 2'd1;
  localparam state_t S_OUTPUT = 2'd2;

  // Adds two sign-extended operands and clamps the result to a signed
  // 'width'-bit range. The caller truncates the return value to 'width' bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input int                          width
  );
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    one    = '0;
    one[0] = 1'b1;
    sum    = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi     = (one <<< (width - 1)) - one;
    lo     = -(one <<< (width - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/synapse_sat_add.sv
// Combinational signed accumulator add, saturating to ACC_W bits.
module synapse_sat_add
  import synapse_pkg::*;
#(
  parameter int ACC_W    = DEF_ACC_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic signed [ACC_W-1:0]    acc_in,
  input  logic signed [WEIGHT_W-1:0] addend,
  output logic signed [ACC_W-1:0]    sum_out
);

  always_comb begin
    sum_out = ACC_W'(sat_add(SAT_MAX_W'(acc_in), SAT_MAX_W'(addend), ACC_W));
  end

endmodule

// File: rtl/synapse_accumulator.sv
// Per-neuron synaptic input stage: connection table, spike capture, and a
// one-connection-per-cycle saturating weight sum handed out over valid/ready.
module synapse_accumulator
  import synapse_pkg::*;
#(
  parameter int NUM_CONN = DEF_NUM_CONN,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int IDX_W    = $clog2(NUM_CONN)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [IDX_W-1:0]           cfg_index,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic signed [WEIGHT_W-1:0] cfg_weight,
  input  logic                       cfg_clear,
  input  logic                       spike_valid,
  input  logic [ADDR_W-1:0]          spike_addr,
  input  logic                       timestep_end,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ACC_W-1:0]    out_sum,
  output logic [IDX_W:0]             out_count,
  output logic                       busy,
  output logic                       overrun
);

  logic [NUM_CONN-1:0]        tbl_valid_q, tbl_valid_d;
  logic [ADDR_W-1:0]          tbl_addr_q   [NUM_CONN];
  logic [ADDR_W-1:0]          tbl_addr_d   [NUM_CONN];
  logic signed [WEIGHT_W-1:0] tbl_weight_q [NUM_CONN];
  logic signed [WEIGHT_W-1:0] tbl_weight_d [NUM_CONN];
  logic [NUM_CONN-1:0]        incoming_q, incoming_d;
  logic [NUM_CONN-1:0]        pending_q, pending_d;
  logic [NUM_CONN-1:0]        match;
  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [IDX_W:0]             count_q, count_d;
  logic                       overrun_q, overrun_d;
  logic                       idle;

  assign idle = (state_q == S_IDLE);

  // Matches use the table as it stood before any write in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CONN; i++) begin
      match[i] = spike_valid && tbl_valid_q[i] && (tbl_addr_q[i] == spike_addr);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tbl_valid_d  = tbl_valid_q;
    tbl_addr_d   = tbl_addr_q;
    tbl_weight_d = tbl_weight_q;
    if (idle) begin
      if (cfg_clear) tbl_valid_d = '0;
      if (cfg_valid) begin
        tbl_valid_d[cfg_index]  = 1'b1;
        tbl_addr_d[cfg_index]   = cfg_addr;
        tbl_weight_d[cfg_index] = cfg_weight;
      end
    end
  end

  synapse_sat_add #(
    .ACC_W    (ACC_W),
    .WEIGHT_W (WEIGHT_W)
  ) u_sat_add (
    .acc_in  (acc_q),
    .addend  (tbl_weight_q[idx_q]),
    .sum_out (acc_sum)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    count_d    = count_q;
    pending_d  = pending_q;
    incoming_d = incoming_q | match;
    overrun_d  = overrun_q || (timestep_end && !idle);
    case (state_q)
      S_IDLE: begin
        if (timestep_end) begin
          pending_d  = incoming_q;
          incoming_d = match;
          acc_d      = '0;
          count_d    = '0;
          idx_d      = '0;
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (pending_q[idx_q]) begin
          acc_d   = acc_sum;
          count_d = count_q + (IDX_W + 1)'(1);
        end
        if (idx_q == IDX_W'(NUM_CONN - 1)) begin
          state_d = S_OUTPUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      tbl_valid_q <= '0;
      incoming_q  <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      tbl_valid_q <= tbl_valid_d;
      incoming_q  <= incoming_d;
      pending_q   <= pending_d;
    end
  end

  // NOTE: table contents stay unreset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    tbl_addr_q   <= tbl_addr_d;
    tbl_weight_q <= tbl_weight_d;
  end

  assign cfg_ready = idle;
  assign busy      = !idle;
  assign out_valid = (state_q == S_OUTPUT);
  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign overrun   = overrun_q;

endmodule
